rr_arb_lock: RTL and testbench

- Registered, parametrised round-robin arbiter with a per-grant lock, for switch egress ports shared by N ingress queues.
- Picks one requester among RR_WIDTH, holds the grant for a whole frame until the winner signals end-of-frame, then rotates priority past the winner.
- Adds a rotating priority pointer, multi-cycle grant hold, abort detection and a hold-timeout watchdog.

---
 rtl/rr_arb_lock.sv | 157 +++++++++++++++
 tb/tb_rr_arb_lock.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_lock.sv
// Round-robin arbiter with per-grant frame lock, abort detection and hold watchdog.
// The grant is registered; priority rotates past each winner.
module rr_arb_lock #(
    parameter int RR_WIDTH    = 8,
    parameter int RR_WIDTH_L2 = $clog2(RR_WIDTH),
    parameter int HOLD_MAX    = 2048,
    parameter int CNT_W       = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RR_WIDTH-1:0]    req,
    input  logic [RR_WIDTH-1:0]    done,
    output logic [RR_WIDTH-1:0]    gnt,
    output logic [RR_WIDTH_L2-1:0] gnt_bin,
    output logic                   gnt_vld,
    output logic                   abort,
    output logic                   tmo
);

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
    localparam bit               WDOG_EN   = (HOLD_MAX != 0);

    state_t                 r_state, w_state_nxt;
    logic [RR_WIDTH-1:0]    r_gnt, w_gnt_nxt;
    logic [RR_WIDTH_L2-1:0] r_gnt_bin, w_gnt_bin_nxt;
    logic                   r_gnt_vld, w_gnt_vld_nxt;
    logic                   r_abort, w_abort_nxt;
    logic                   r_tmo, w_tmo_nxt;
    logic [RR_WIDTH_L2-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]       r_hold, w_hold_nxt;

    logic [RR_WIDTH-1:0]    w_cand;
    logic [RR_WIDTH-1:0]    w_rot;
    logic                   w_any;
    logic [RR_WIDTH_L2-1:0] w_off;
    logic [RR_WIDTH_L2:0]   w_sum;
    logic [RR_WIDTH_L2-1:0] w_win;
    logic [RR_WIDTH_L2-1:0] w_win_inc;
    logic                   w_done_g;
    logic                   w_req_g;
    logic                   w_tmo_hit;
    logic                   w_release;
    logic                   w_load;

    // Rotating scan: rotate candidates so ptr lands at bit 0, take the first set bit,
    // then map the offset back to an absolute index modulo RR_WIDTH.
    always_comb begin
        w_cand = req & ~r_gnt;
        w_rot  = RR_WIDTH'({w_cand, w_cand} >> r_ptr);
        w_any  = 1'b0;
        w_off  = '0;
        for (int unsigned i = 0; i < RR_WIDTH; i++) begin
            if (!w_any && w_rot[RR_WIDTH_L2'(i)]) begin
                w_any = 1'b1;
                w_off = RR_WIDTH_L2'(i);
            end
        end
        w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
        w_win     = (w_sum >= (RR_WIDTH_L2+1)'(RR_WIDTH))
                    ? RR_WIDTH_L2'(w_sum - (RR_WIDTH_L2+1)'(RR_WIDTH))
                    : RR_WIDTH_L2'(w_sum);
        w_win_inc = (w_win == RR_WIDTH_L2'(RR_WIDTH - 1)) ? '0 : w_win + RR_WIDTH_L2'(1);
    end

    assign w_done_g  = |(done & r_gnt);
    assign w_req_g   = |(req & r_gnt);
    assign w_tmo_hit = WDOG_EN && (r_hold == HOLD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_bin_nxt = r_gnt_bin;
        w_gnt_vld_nxt = r_gnt_vld;
        w_abort_nxt   = 1'b0;
        w_tmo_nxt     = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_release     = 1'b0;
        w_load        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_load = w_any;
            end
            S_LOCK: begin
                if (r_hold < HOLD_SAT) begin
                    w_hold_nxt = r_hold + CNT_W'(1);
                end
                if (w_done_g) begin
                    w_release = 1'b1;
                end else if (!w_req_g) begin
                    w_release   = 1'b1;
                    w_abort_nxt = 1'b1;
                end else if (w_tmo_hit) begin
                    w_release = 1'b1;
                    w_tmo_nxt = 1'b1;
                end
                if (w_release) begin
                    if (w_any) begin
                        w_load = 1'b1;
                    end else begin
                        w_gnt_nxt     = '0;
                        w_gnt_vld_nxt = 1'b0;
                        w_state_nxt   = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_gnt_nxt     = RR_WIDTH'(1) << w_win;
            w_gnt_bin_nxt = w_win;
            w_gnt_vld_nxt = 1'b1;
            w_ptr_nxt     = w_win_inc;
            w_hold_nxt    = '0;
            w_state_nxt   = S_LOCK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_gnt_bin <= '0;
            r_gnt_vld <= 1'b0;
            r_abort   <= 1'b0;
            r_tmo     <= 1'b0;
            r_ptr     <= '0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_bin <= w_gnt_bin_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
            r_abort   <= w_abort_nxt;
            r_tmo     <= w_tmo_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_bin = r_gnt_bin;
    assign gnt_vld = r_gnt_vld;
    assign abort   = r_abort;
    assign tmo     = r_tmo;

endmodule

// File: tb/tb_rr_arb_lock.sv
// Bench for rr_arb_lock: an 8-wide (HOLD_MAX=16) and a 5-wide (HOLD_MAX=6) instance,
// checked every cycle against a behavioural reference model plus directed expectations.
module tb_rr_arb_lock;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req8 = '0, done8 = '0;
    logic [4:0] req5 = '0, done5 = '0;

    logic [7:0] gnt8;
    logic [2:0] bin8;
    logic       vld8, abort8, tmo8;
    logic [4:0] gnt5;
    logic [2:0] bin5;
    logic       vld5, abort5, tmo5;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arb_lock #(.RR_WIDTH(8), .HOLD_MAX(16), .CNT_W(5)) u_dut8 (
        .clk(clk), .rst(rst), .req(req8), .done(done8),
        .gnt(gnt8), .gnt_bin(bin8), .gnt_vld(vld8), .abort(abort8), .tmo(tmo8)
    );

    rr_arb_lock #(.RR_WIDTH(5), .HOLD_MAX(6), .CNT_W(3)) u_dut5 (
        .clk(clk), .rst(rst), .req(req5), .done(done5),
        .gnt(gnt5), .gnt_bin(bin5), .gnt_vld(vld5), .abort(abort5), .tmo(tmo5)
    );

    // Reference model state, index 0 = 8-wide instance, 1 = 5-wide instance.
    int W[2]  = '{8, 5};
    int HM[2] = '{16, 6};
    int m_ptr[2], m_g[2], m_bin[2], m_hold[2];
    bit m_abort[2], m_tmo[2];

    function automatic bit bit_at(logic [7:0] v, int i);
        return ((v >> i) & 8'd1) != 8'd0;
    endfunction

    // First requester at ptr, ptr+1, ... modulo width; -1 when nobody requests.
    function automatic int arb(int k, logic [7:0] v, int p);
        for (int o = 0; o < W[k]; o++) begin
            int idx;
            idx = (p + o) % W[k];
            if (bit_at(v, idx)) return idx;
        end
        return -1;
    endfunction

    task automatic grant(int k, int w);
        m_g[k]    = w;
        m_bin[k]  = w;
        m_ptr[k]  = (w + 1) % W[k];
        m_hold[k] = 0;
    endtask

    task automatic model_step(int k, logic [7:0] r, logic [7:0] d);
        int  w;
        int  g;
        bit  rel;
        m_abort[k] = 1'b0;
        m_tmo[k]   = 1'b0;
        if (rst) begin
            m_ptr[k] = 0; m_g[k] = -1; m_bin[k] = 0; m_hold[k] = 0;
        end else if (m_g[k] < 0) begin
            w = arb(k, r, m_ptr[k]);
            if (w >= 0) grant(k, w);
        end else begin
            g   = m_g[k];
            rel = 1'b0;
            if (bit_at(d, g)) rel = 1'b1;
            else if (!bit_at(r, g)) begin rel = 1'b1; m_abort[k] = 1'b1; end
            else if (HM[k] != 0 && m_hold[k] == HM[k] - 1) begin rel = 1'b1; m_tmo[k] = 1'b1; end
            if (m_hold[k] < HM[k]) m_hold[k]++;
            if (rel) begin
                w = arb(k, r & ~(8'd1 << g), m_ptr[k]);
                if (w >= 0) grant(k, w);
                else m_g[k] = -1;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_gnt(int k);
        return (m_g[k] < 0) ? 32'd0 : (32'd1 << m_g[k]);
    endfunction

    task automatic check_all();
        chk("g8_gnt",   {24'd0, gnt8},  exp_gnt(0));
        chk("g8_bin",   {29'd0, bin8},  32'(m_bin[0]));
        chk("g8_vld",   {31'd0, vld8},  {31'd0, m_g[0] >= 0});
        chk("g8_abort", {31'd0, abort8}, {31'd0, m_abort[0]});
        chk("g8_tmo",   {31'd0, tmo8},  {31'd0, m_tmo[0]});
        chk("g5_gnt",   {27'd0, gnt5},  exp_gnt(1));
        chk("g5_bin",   {29'd0, bin5},  32'(m_bin[1]));
        chk("g5_vld",   {31'd0, vld5},  {31'd0, m_g[1] >= 0});
        chk("g5_abort", {31'd0, abort5}, {31'd0, m_abort[1]});
        chk("g5_tmo",   {31'd0, tmo5},  {31'd0, m_tmo[1]});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, req8, done8);
        model_step(1, {3'b0, req5}, {3'b0, done5});
        #1;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int q8[$];
        int q5[$];
        int seq8[9];
        int seq5[4];
        seq8 = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        seq5 = '{0, 4, 0, 4};
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_g[k] = -1; m_bin[k] = 0; m_hold[k] = 0;
            m_abort[k] = 1'b0; m_tmo[k] = 1'b0;
        end

        // Reset, then idle requests.
        rst = 1'b1;
        tick(); tick();
        chk("rst_gnt8", {24'd0, gnt8}, 32'd0);
        chk("rst_vld8", {31'd0, vld8}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // All requesting, done three cycles into each grant: sequence 0..7,0 with no gaps.
        req8 = 8'hFF;
        for (int c = 0; c < 60 && q8.size() < 9; c++) begin
            done8 = (m_g[0] >= 0 && m_hold[0] == 2) ? 8'(8'd1 << m_g[0]) : 8'd0;
            tick();
            if (m_g[0] >= 0 && m_hold[0] == 0) q8.push_back(int'(bin8));
        end
        chk("seq8_len", 32'(q8.size()), 32'd9);
        for (int i = 0; i < q8.size() && i < 9; i++) chk("seq8", 32'(q8[i]), 32'(seq8[i]));

        // Grant 4 (ptr -> 5), then req 8'h11: 0 wins before 4 is re-granted.
        done8 = 8'h00; req8 = 8'h10;
        tick();
        chk("p5_abort", {31'd0, abort8}, 32'd1);
        chk("p5_bin4",  {29'd0, bin8}, 32'd4);
        req8 = 8'h11; done8 = 8'h10;
        tick();
        chk("p5_bin0", {29'd0, bin8}, 32'd0);
        done8 = 8'h01;
        tick();
        chk("p5_bin4b", {29'd0, bin8}, 32'd4);
        done8 = 8'h00; req8 = 8'h00;
        tick();
        chk("p5_idle", {31'd0, vld8}, 32'd0);

        // Abort of index 2: gnt moves to 5 in the same cycle.
        req8 = 8'h04;
        tick();
        chk("ab_gnt2", {24'd0, gnt8}, 32'h04);
        req8 = 8'h20;
        tick();
        chk("ab_pulse", {31'd0, abort8}, 32'd1);
        chk("ab_gnt5", {24'd0, gnt8}, 32'h20);
        tick();
        chk("ab_once", {31'd0, abort8}, 32'd0);

        // Watchdog: lone requester 0, no done -> tmo 16 cycles after grant, re-grant after one idle.
        req8 = 8'h01;
        tick();
        chk("to_gnt0", {24'd0, gnt8}, 32'h01);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("to_pulse", {31'd0, tmo8}, {31'd0, i == 16});
        end
        chk("to_drop", {24'd0, gnt8}, 32'd0);
        tick();
        chk("to_regnt", {24'd0, gnt8}, 32'h01);
        req8 = 8'h00;
        tick();

        // 5-wide: req 5'b10001 alternates 0,4,0,4; then reset mid-grant.
        req5 = 5'b10001;
        for (int c = 0; c < 40 && q5.size() < 4; c++) begin
            done5 = (m_g[1] >= 0 && m_hold[1] == 1) ? 5'(5'd1 << m_g[1]) : 5'd0;
            tick();
            if (m_g[1] >= 0 && m_hold[1] == 0) q5.push_back(int'(bin5));
        end
        chk("seq5_len", 32'(q5.size()), 32'd4);
        for (int i = 0; i < q5.size() && i < 4; i++) chk("seq5", 32'(q5[i]), 32'(seq5[i]));
        done5 = 5'd0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst5_gnt", {27'd0, gnt5}, 32'd0);
        chk("rst5_bin", {29'd0, bin5}, 32'd0);
        chk("rst5_vld", {31'd0, vld5}, 32'd0);
        rst = 1'b0; req5 = 5'd0;
        tick();

        // Randomised traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) req8 = 8'($urandom);
            if ($urandom_range(7) == 0) req5 = 5'($urandom);
            done8 = ($urandom_range(5) == 0) ? 8'($urandom) : 8'd0;
            done5 = ($urandom_range(5) == 0) ? 5'($urandom) : 5'd0;
            rst   = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
